abdulov_layer_scanner: RTL

- Sequences reads from one 2-bit layer ROM (X_LIMIT×Y_LIMIT, linear address y*X_LIMIT+x, 1-cycle registered read latency) and emits one frame of pixels in raster order on a valid/ready stream to the layer mixer / ST7789 pixel path.
- Supports per-frame scroll offsets for animation; offsets are sampled at frame start.
- Absorbs ROM latency and downstream backpressure with a 2-entry output buffer so no pixel is lost or duplicated.

---
 rtl/abdulov_layer_pkg.sv | 14 +
 rtl/abdulov_pixel_fifo2.sv | 69 ++++++
 rtl/abdulov_layer_scanner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/abdulov_layer_pkg.sv
// Shared types and constants for the layer ROM scanner.
package abdulov_layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  localparam int PIX_W       = 2;
  localparam int DEF_X_LIMIT = 240;
  localparam int DEF_Y_LIMIT = 240;

endpackage

// File: rtl/abdulov_pixel_fifo2.sv
// Two-entry pixel FIFO (code + last tag) between ROM read data and the pixel stream.
module abdulov_pixel_fifo2
  import abdulov_layer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [PIX_W-1:0] head_data,
  output logic             head_last,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [PIX_W-1:0] data_q [2];
  logic [PIX_W-1:0] data_d [2];
  logic [1:0]       last_q, last_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    if (push) begin
      data_d[wr_q] = push_data;
      last_d[wr_q] = push_last;
      wr_d         = ~wr_q;
    end
    if (pop_ok) begin
      rd_d = ~rd_q;
    end
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_data  = data_q[rd_q];
  assign head_last  = last_q[rd_q] && head_valid;
  assign count      = count_q;

endmodule

// File: rtl/abdulov_layer_scanner.sv
// Scans one layer ROM frame in raster order with wrap-around scroll offsets.
// state | meaning
// IDLE  | waiting for FRAME_START
// SCAN  | first cycle computes row base, then issues ROM addresses
// DRAIN | all addresses issued, waiting for the last pixel handshake
module abdulov_layer_scanner
  import abdulov_layer_pkg::*;
#(
  parameter int X_LIMIT = DEF_X_LIMIT,
  parameter int Y_LIMIT = DEF_Y_LIMIT,
  parameter int ADDR_W  = $clog2(X_LIMIT) + $clog2(Y_LIMIT)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FRAME_START,
  input  logic [$clog2(X_LIMIT)-1:0] X_OFFSET,
  input  logic [$clog2(Y_LIMIT)-1:0] Y_OFFSET,
  output logic                       FRAME_BUSY,
  output logic                       FRAME_DONE,
  output logic [ADDR_W-1:0]          ROM_ADDRESS,
  input  logic [PIX_W-1:0]           ROM_DATA,
  output logic [PIX_W-1:0]           PIXEL_DATA,
  output logic                       PIXEL_VALID,
  input  logic                       PIXEL_READY,
  output logic                       PIXEL_LAST
);

  localparam int XW = $clog2(X_LIMIT);
  localparam int YW = $clog2(Y_LIMIT);
  localparam logic [XW:0]       X_LIM_C    = (XW+1)'(X_LIMIT);
  localparam logic [YW:0]       Y_LIM_C    = (YW+1)'(Y_LIMIT);
  localparam logic [XW-1:0]     X_MAX      = XW'(X_LIMIT - 1);
  localparam logic [YW-1:0]     Y_MAX      = YW'(Y_LIMIT - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(X_LIMIT);

  scan_state_t       state_q, state_d;
  logic              prep_q, prep_d;
  logic [XW-1:0]     xoff_q, xoff_d;
  logic [XW-1:0]     x_q, x_d, sx_q, sx_d;
  logic [YW-1:0]     y_q, y_d, sy_q, sy_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_count;
  logic              pop, issue, last_pix;
  logic [2:0]        occ;
  logic [XW-1:0]     xo_clamp;
  logic [YW-1:0]     yo_clamp;

  always_comb begin
    state_d         = state_q;
    prep_d          = prep_q;
    xoff_d          = xoff_q;
    x_d             = x_q;
    y_d             = y_q;
    sx_d            = sx_q;
    sy_d            = sy_q;
    row_base_d      = row_base_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    xo_clamp        = ({1'b0, X_OFFSET} >= X_LIM_C) ? '0 : X_OFFSET;
    yo_clamp        = ({1'b0, Y_OFFSET} >= Y_LIM_C) ? '0 : Y_OFFSET;
    pop             = PIXEL_VALID && PIXEL_READY;
    // Occupancy the buffer will have once this cycle's push and pop settle.
    occ             = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    issue           = (state_q == SCAN) && !prep_q && (occ < 3'd2);
    last_pix        = (x_q == X_MAX) && (y_q == Y_MAX);
    inflight_d      = issue;
    inflight_last_d = issue && last_pix;

    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          xoff_d  = xo_clamp;
          sx_d    = xo_clamp;
          sy_d    = yo_clamp;
          x_d     = '0;
          y_d     = '0;
          prep_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (prep_q) begin
          row_base_d = ADDR_W'(sy_q) * ROW_STRIDE;
          prep_d     = 1'b0;
        end else if (issue) begin
          if (x_q == X_MAX) begin
            x_d  = '0;
            y_d  = y_q + 1'b1;
            sx_d = xoff_q;
            if (sy_q == Y_MAX) begin
              sy_d       = '0;
              row_base_d = '0;
            end else begin
              sy_d       = sy_q + 1'b1;
              row_base_d = row_base_q + ROW_STRIDE;
            end
          end else begin
            x_d  = x_q + 1'b1;
            sx_d = (sx_q == X_MAX) ? '0 : sx_q + 1'b1;
          end
          if (last_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && PIXEL_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      prep_q          <= 1'b0;
      xoff_q          <= '0;
      x_q             <= '0;
      y_q             <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      row_base_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      prep_q          <= prep_d;
      xoff_q          <= xoff_d;
      x_q             <= x_d;
      y_q             <= y_d;
      sx_q            <= sx_d;
      sy_q            <= sy_d;
      row_base_q      <= row_base_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  abdulov_pixel_fifo2 u_fifo (
    .clk        (CLK),
    .rst        (RESET),
    .push       (inflight_q),
    .push_data  (ROM_DATA),
    .push_last  (inflight_last_q),
    .pop        (pop),
    .head_data  (PIXEL_DATA),
    .head_last  (PIXEL_LAST),
    .head_valid (PIXEL_VALID),
    .count      (fifo_count)
  );

  assign ROM_ADDRESS = row_base_q + ADDR_W'(sx_q);
  assign FRAME_BUSY  = busy_q;
  assign FRAME_DONE  = done_q;

endmodule
